// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: request entry, FSM states and constants shared by the memory sequencer
package mem_seq_pkg;
  localparam logic CMD_RD = 1'b0;
  localparam logic CMD_WR = 1'b1;
  localparam logic W_BYTE = 1'b0;
  localparam logic W_WORD = 1'b1;
  localparam logic [15:0] TMO_FILL = 16'hFFFF;
  typedef struct packed {
    logic        cmd;
    logic        width;
    logic [15:0] addr;
    logic [15:0] data;
    logic        tid;
  } req_t;
  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;
endpackage

// File: rtl/mem_req_fifo.sv
// mem_req_fifo: synchronous request queue of DEPTH entries (DEPTH a power of two)
module mem_req_fifo
  import mem_seq_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  req_t                   wr_data,
  output req_t                   rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  req_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign rd_data = mem[rp];
  // storage is not reset; only the pointers define validity
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= wr_data;
  // pointers and occupancy
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/mem_seq_ctrl.sv
// mem_seq_ctrl: queues core memory requests and runs them as byte cycles on an 8-bit bus; MEM_SEQ_TIMEOUT_EN adds a bus-ack watchdog
module mem_seq_ctrl
  import mem_seq_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        a_rst,
  input  logic        rq_start,
  input  logic        rq_cmd,
  input  logic        rq_width,
  input  logic [15:0] rq_addr,
  input  logic [15:0] rq_data,
  input  logic        rq_tid,
  output logic        core_hold,
  output logic [15:0] data_out,
  output logic        data_tid,
  output logic        data_wr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  input  logic        bus_ack,
  output logic        busy,
  output logic        err
);
  state_t state, nxt;
  req_t cur, head;
  logic [15:0] rdata;
  logic [$clog2(DEPTH):0] count;
  logic empty, pop, in_bus, rd, tmo;
  assign pop = state == IDLE && !empty;
  assign in_bus = state == LO || state == HI;
  assign rd = cur.cmd == CMD_RD;
  assign busy = count != '0 || state != IDLE;
  assign bus_req = in_bus;
  assign bus_we = in_bus & cur.cmd;
  assign bus_addr = state == LO ? cur.addr : state == HI ? cur.addr + 16'd1 : '0;
  assign bus_wdata = state == LO ? cur.data[7:0] : state == HI ? cur.data[15:8] : '0;
  mem_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(a_rst),
    .push(rq_start),
    .pop(pop),
    .wr_data('{cmd: rq_cmd, width: rq_width, addr: rq_addr, data: rq_data, tid: rq_tid}),
    .rd_data(head),
    .full(core_hold),
    .empty(empty),
    .count(count)
  );
`ifdef MEM_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] cnt;
  assign tmo = in_bus & ~bus_ack & (cnt == TW'(TIMEOUT_CYC - 1));
  // cycles spent waiting for ack in the current bus cycle
  always_ff @(posedge clk)
    cnt <= (a_rst | ~in_bus | bus_ack | tmo) ? '0 : cnt + TW'(1);
`else
  assign tmo = 1'b0;
`endif
  // state register
  always_ff @(posedge clk)
    state <= a_rst ? IDLE : nxt;
  // next state; a timeout abandons the access like a final ack would end it
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = empty ? IDLE : LO;
      LO: nxt = tmo ? (rd ? RESP : IDLE) : !bus_ack ? LO : cur.width == W_WORD ? HI : rd ? RESP : IDLE;
      HI: nxt = (tmo | bus_ack) ? (rd ? RESP : IDLE) : HI;
      default: nxt = IDLE;
    endcase
  end
  // working request, read assembly, response strobe and sticky error
  always_ff @(posedge clk)
    if (a_rst) begin
      cur <= '0;
      rdata <= '0;
      data_out <= '0;
      data_tid <= 1'b0;
      data_wr <= 1'b0;
      err <= 1'b0;
    end else begin
      data_wr <= state == RESP;
      if (state == RESP) begin
        data_out <= rdata;
        data_tid <= cur.tid;
      end
      if (pop) begin
        cur <= head;
        rdata <= '0;
      end
      if (state == LO && bus_ack) rdata[7:0] <= bus_rdata;
      if (state == HI && bus_ack) rdata[15:8] <= bus_rdata;
      if (tmo) rdata <= TMO_FILL;
      if ((rq_start && core_hold) || tmo) err <= 1'b1;
    end
endmodule

// File: tb/tb_mem_seq_ctrl.sv
// tb_mem_seq_ctrl: directed tests with a queue-based model of expected bus cycles and read responses
module tb_mem_seq_ctrl;
  localparam int TMO = 8;
  logic clk = 1'b0, a_rst = 1'b1, rq_start = 1'b0, rq_cmd = 1'b0, rq_width = 1'b0, rq_tid = 1'b0, ack_en = 1'b0;
  logic [15:0] rq_addr = '0, rq_data = '0;
  logic core_hold, data_tid, data_wr, bus_req, bus_we, bus_ack, busy, err;
  logic [15:0] data_out, bus_addr;
  logic [7:0] bus_wdata, bus_rdata;
  typedef struct {int id; logic [15:0] addr; logic we; logic [7:0] wd;} bus_t;
  typedef struct {int id; logic [15:0] d; logic tid;} rsp_t;
  bus_t bq[$];
  rsp_t rsq[$];
  int nid = 0, wcnt = 0, errors = 0, checks = 0;

  mem_seq_ctrl #(.DEPTH(2), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .a_rst(a_rst), .rq_start(rq_start), .rq_cmd(rq_cmd), .rq_width(rq_width),
    .rq_addr(rq_addr), .rq_data(rq_data), .rq_tid(rq_tid), .core_hold(core_hold),
    .data_out(data_out), .data_tid(data_tid), .data_wr(data_wr), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // bus slave contents: a few fixed bytes, everything else a hash of the address
  function automatic logic [7:0] bval(input logic [15:0] a);
    case (a)
      16'h1234: return 8'hAB;
      16'hFFFF: return 8'h34;
      16'h0000: return 8'h12;
      default:  return a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  assign bus_rdata = bval(bus_addr);
  assign bus_ack = ack_en & bus_req;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // an accepted request expands into its byte cycles and, for reads, one response
  function automatic void model_add(input logic cmd, input logic w, input logic [15:0] a,
                                    input logic [15:0] d, input logic t);
    logic [15:0] a1;
    a1 = a + 16'd1;
    bq.push_back('{nid, a, cmd, d[7:0]});
    if (w) bq.push_back('{nid, a1, cmd, d[15:8]});
    if (!cmd) rsq.push_back('{nid, w ? {bval(a1), bval(a)} : {8'h00, bval(a)}, t});
    nid++;
  endfunction

  task automatic push(input logic cmd, input logic w, input logic [15:0] a, input logic [15:0] d,
                      input logic t, input logic hold);
    @(negedge clk);
    chk("core_hold", core_hold, hold);
    rq_start = 1'b1; rq_cmd = cmd; rq_width = w; rq_addr = a; rq_data = d; rq_tid = t;
    @(posedge clk);
    if (!hold) model_add(cmd, w, a, d, t);
    #1 rq_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || data_wr || bq.size() != 0 || rsq.size() != 0) && n < 300);
    checks++;
    if (busy || bq.size() != 0 || rsq.size() != 0) begin
      errors++;
      $display("FAIL drain: busy=%0b bus_left=%0d rsp_left=%0d after %0d cycles", busy, bq.size(), rsq.size(), n);
    end
  endtask

  // every cycle: bus outputs against the next expected byte cycle, strobes against the next response
  always @(negedge clk)
    if (!a_rst) begin
      if (bus_req) begin
        if (bq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_extra: unexpected bus cycle addr=%0h", bus_addr);
        end else begin
          chk("bus_addr", bus_addr, bq[0].addr);
          chk("bus_we", bus_we, bq[0].we);
          chk("bus_wdata", bus_wdata, bq[0].wd);
          if (bus_ack) begin
            void'(bq.pop_front());
            wcnt = 0;
          end else begin
            wcnt++;
`ifdef MEM_SEQ_TIMEOUT_EN
            if (wcnt == TMO) begin
              int id;
              id = bq[0].id;
              while (bq.size() != 0 && bq[0].id == id) void'(bq.pop_front());
              foreach (rsq[i]) if (rsq[i].id == id) rsq[i].d = 16'hFFFF;
              wcnt = 0;
            end
`endif
          end
        end
      end
      if (data_wr) begin
        if (rsq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL data_extra: unexpected data_wr data_out=%0h", data_out);
        end else begin
          chk("data_out", data_out, rsq[0].d);
          chk("data_tid", data_tid, rsq[0].tid);
          void'(rsq.pop_front());
        end
      end
    end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hold", core_hold, 0); chk("rst_data_wr", data_wr, 0); chk("rst_data_out", data_out, 0);
    chk("rst_data_tid", data_tid, 0); chk("rst_bus_req", bus_req, 0); chk("rst_bus_we", bus_we, 0);
    chk("rst_bus_addr", bus_addr, 0); chk("rst_bus_wdata", bus_wdata, 0); chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    @(posedge clk);
    #1 a_rst = 1'b0;
    ack_en = 1'b1;

    // byte read, zero-wait ack: strobe on the fourth cycle after the push edge
    push(1'b0, 1'b0, 16'h1234, 16'h0000, 1'b1, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("lat_byte_early", data_wr, 0);
    end
    @(negedge clk);
    chk("lat_byte", data_wr, 1);
    chk("byte_data", data_out, 16'h00AB);
    chk("byte_tid", data_tid, 1);
    wait_idle();

    // word write: low byte then high byte, no response
    push(1'b1, 1'b1, 16'h2000, 16'hBEEF, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("ww_lo_addr", bus_addr, 16'h2000); chk("ww_lo_wdata", bus_wdata, 8'hEF); chk("ww_lo_we", bus_we, 1);
    @(negedge clk);
    chk("ww_hi_addr", bus_addr, 16'h2001); chk("ww_hi_wdata", bus_wdata, 8'hBE); chk("ww_hi_we", bus_we, 1);
    wait_idle();
    chk("data_hold", data_out, 16'h00AB);

    // word read across the address wrap: strobe on the fifth cycle
    push(1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
    @(negedge clk);
    chk("wr_early1", data_wr, 0);
    @(negedge clk);
    chk("wrap_lo_addr", bus_addr, 16'hFFFF);
    @(negedge clk);
    chk("wrap_hi_addr", bus_addr, 16'h0000);
    @(negedge clk);
    chk("wr_early4", data_wr, 0);
    @(negedge clk);
    chk("lat_word", data_wr, 1);
    chk("wrap_data", data_out, 16'h1234);
    wait_idle();
    chk("err_clean", err, 0);

    // stalled bus: working register plus two queued entries, the fourth start is dropped
    ack_en = 1'b0;
    push(1'b0, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0);
    push(1'b1, 1'b1, 16'h0100, 16'hCAFE, 1'b1, 1'b0);
    push(1'b0, 1'b1, 16'h0200, 16'h0000, 1'b0, 1'b0);
    push(1'b0, 1'b0, 16'h0300, 16'h0000, 1'b1, 1'b1);
    @(negedge clk);
    chk("overflow_err", err, 1);
    chk("overflow_hold", core_hold, 1);
    ack_en = 1'b1;
    wait_idle();

    // reset during the high byte of a word read
    push(1'b0, 1'b1, 16'h3000, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rr_lo_addr", bus_addr, 16'h3000);
    @(posedge clk);
    #1 a_rst = 1'b1;
    bq.delete();
    rsq.delete();
    wcnt = 0;
    @(negedge clk);
    chk("rr_hi_addr", bus_addr, 16'h3001);
    @(posedge clk);
    #1 a_rst = 1'b0;
    @(negedge clk);
    chk("rr_bus_req", bus_req, 0); chk("rr_busy", busy, 0); chk("rr_data_wr", data_wr, 0);
    chk("rr_hold", core_hold, 0); chk("rr_err", err, 0);
    repeat (6) @(negedge clk);
    wait_idle();

`ifdef MEM_SEQ_TIMEOUT_EN
    // unacknowledged read is abandoned with the fill value; the queued write then runs normally
    ack_en = 1'b0;
    push(1'b0, 1'b0, 16'h0500, 16'h0000, 1'b1, 1'b0);
    push(1'b1, 1'b0, 16'h0600, 16'h0077, 1'b0, 1'b0);
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!data_wr && n < 60);
      chk("tmo_strobe", data_wr, 1);
    end
    ack_en = 1'b1;
    chk("tmo_data", data_out, 16'hFFFF);
    chk("tmo_tid", data_tid, 1);
    chk("tmo_err", err, 1);
    wait_idle();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
